// File: rtl/data_mem_bridge_if.sv
// data_mem_bridge_if
// CPU-side data-port bundle between the single-cycle CPU and data_mem_bridge.
//   master : the CPU. It drives the request, the store data and the access type.
//            It receives the load result, the ready pulse and the error flag.
//   slave  : the bridge.
// Signals:
//   cpu_req, cpu_we, cpu_addr[31:0], cpu_wdata[31:0], cpu_dmtype[2:0]  (CPU -> bridge)
//   cpu_rdata[31:0], cpu_ready, cpu_err                                (bridge -> CPU)
interface data_mem_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_dmtype;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
    input  cpu_rdata, cpu_ready, cpu_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
    output cpu_rdata, cpu_ready, cpu_err
  );
endinterface

// File: rtl/data_mem_bridge.sv
// data_mem_bridge
// Load/store bridge between the CPU data port and a synchronous block-RAM.
// The bridge handles one access at a time.
//   - Stores produce byte-lane write enables and lane-replicated write data.
//   - Loads wait out the RAM read latency. The addressed byte, halfword or word
//     is then extracted and extended.
//   - Misaligned accesses and illegal types get an error response. The RAM is
//     not touched for them.
// Ports:
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low
//   cpu        : data_mem_bridge_if.slave (request/ready handshake with the CPU)
//   ram_en     : RAM enable, asserted only in WRITE and READ
//   ram_wea    : per-byte write enables; bit k covers ram_wdata[8k+7:8k]
//   ram_addr   : RAM word address, taken from cpu_addr[RAM_AW+1:2]
//   ram_wdata  : lane-replicated store data
//   ram_rdata  : RAM read data, valid RD_LAT cycles after the ram_en cycle
// Parameters:
//   RAM_AW : word-address width of the RAM
//   RD_LAT : RAM read latency in cycles, 1..3
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for cpu_req; the access is latched and checked here
// WRITE | RAM write cycle (ram_en, ram_wea, ram_addr, ram_wdata driven)
// READ  | RAM read cycle (ram_en, ram_addr driven, ram_wea = 0)
// WAIT  | counting down the RAM read latency; capture rdata at count 0
// RESP  | one-cycle cpu_ready pulse; cpu_req is ignored
module data_mem_bridge #(
  parameter int RAM_AW = 10,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_bridge_if.slave    cpu,
  output logic                ram_en,
  output logic [3:0]          ram_wea,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_rdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  state_t      state;
  logic [1:0]  wait_cnt;
  logic [1:0]  lat_off;
  logic [2:0]  lat_type;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;

  logic        req_bad;
  logic [3:0]  st_wea;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Address bits above the RAM range are dropped on purpose, so the RAM wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu.cpu_addr[31:RAM_AW+2];

  assign cpu.cpu_rdata = rdata_q;
  assign cpu.cpu_ready = ready_q;
  assign cpu.cpu_err   = err_q;

  // Decode of the incoming request. It is evaluated in IDLE against the live
  // request, so the RAM-side outputs can be registered at the sampling edge.
  always_comb begin
    req_bad  = 1'b0;
    st_wea   = 4'b0000;
    st_wdata = 32'h0;
    case (cpu.cpu_dmtype)
      3'd0: begin
        req_bad  = (cpu.cpu_addr[1:0] != 2'b00);
        st_wea   = 4'b1111;
        st_wdata = cpu.cpu_wdata;
      end
      3'd1, 3'd2: begin
        req_bad  = cpu.cpu_addr[0];
        st_wea   = cpu.cpu_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{cpu.cpu_wdata[15:0]}};
      end
      3'd3, 3'd4: begin
        st_wea   = 4'b0001 << cpu.cpu_addr[1:0];
        st_wdata = {4{cpu.cpu_wdata[7:0]}};
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Lane extraction from the RAM word. It uses the latched offset and type.
  always_comb begin
    ld_byte = 8'h00;
    ld_data = 32'h0;
    case (lat_off)
      2'd0:    ld_byte = ram_rdata[7:0];
      2'd1:    ld_byte = ram_rdata[15:8];
      2'd2:    ld_byte = ram_rdata[23:16];
      default: ld_byte = ram_rdata[31:24];
    endcase
    ld_half = lat_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (lat_type)
      3'd0:    ld_data = ram_rdata;
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_data = {16'h0, ld_half};
      3'd3:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_data = {24'h0, ld_byte};
      default: ld_data = 32'h0;
    endcase
  end

  // Each output is registered at the edge that enters the state owning it.
  // So ram_en/ram_wea are set on the way into WRITE/READ, and cpu_ready is
  // set on the way into RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 2'd0;
      lat_off   <= 2'd0;
      lat_type  <= 3'd0;
      rdata_q   <= 32'h0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      ram_en    <= 1'b0;
      ram_wea   <= 4'b0000;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
    end else begin
      ram_en  <= 1'b0;
      ram_wea <= 4'b0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu.cpu_req) begin
            lat_off  <= cpu.cpu_addr[1:0];
            lat_type <= cpu.cpu_dmtype;
            if (req_bad) begin
              rdata_q <= 32'h0;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              state   <= RESP;
            end else begin
              ram_en   <= 1'b1;
              ram_addr <= cpu.cpu_addr[RAM_AW+1:2];
              if (cpu.cpu_we) begin
                ram_wea   <= st_wea;
                ram_wdata <= st_wdata;
                state     <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end
        WRITE: begin
          ready_q <= 1'b1;
          state   <= RESP;
        end
        READ: begin
          wait_cnt <= WAIT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            rdata_q <= ld_data;
            ready_q <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge
// Drives two bridges, one with RD_LAT=1 and one with RD_LAT=3. Each bridge has
// its own behavioural RAM. A byte-level reference memory computes the expected
// response of every access when it is issued, and queues it. A monitor pops
// and compares that response when cpu_ready appears.
module tb_data_mem_bridge;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  data_mem_bridge_if bus0();
  data_mem_bridge_if bus1();

  logic        req[2];
  logic        we[2];
  logic [31:0] addr[2];
  logic [31:0] wd[2];
  logic [2:0]  ty[2];

  assign bus0.cpu_req = req[0];  assign bus1.cpu_req = req[1];
  assign bus0.cpu_we  = we[0];   assign bus1.cpu_we  = we[1];
  assign bus0.cpu_addr = addr[0]; assign bus1.cpu_addr = addr[1];
  assign bus0.cpu_wdata = wd[0];  assign bus1.cpu_wdata = wd[1];
  assign bus0.cpu_dmtype = ty[0]; assign bus1.cpu_dmtype = ty[1];

  logic [31:0] rdata[2];
  logic        ready[2];
  logic        err[2];
  assign rdata[0] = bus0.cpu_rdata; assign rdata[1] = bus1.cpu_rdata;
  assign ready[0] = bus0.cpu_ready; assign ready[1] = bus1.cpu_ready;
  assign err[0]   = bus0.cpu_err;   assign err[1]   = bus1.cpu_err;

  logic        en0, en1;
  logic [3:0]  wea0, wea1;
  logic [9:0]  ra0, ra1;
  logic [31:0] wdat0, wdat1;
  logic [31:0] rrd0, rrd1;

  logic        en_a[2];
  logic [3:0]  wea_a[2];
  logic [9:0]  ra_a[2];
  logic [31:0] wdat_a[2];
  assign en_a[0] = en0;     assign en_a[1] = en1;
  assign wea_a[0] = wea0;   assign wea_a[1] = wea1;
  assign ra_a[0] = ra0;     assign ra_a[1] = ra1;
  assign wdat_a[0] = wdat0; assign wdat_a[1] = wdat1;

  data_mem_bridge #(.RAM_AW(10), .RD_LAT(LAT0)) dut0 (
    .clk(clk), .reset(reset), .cpu(bus0),
    .ram_en(en0), .ram_wea(wea0), .ram_addr(ra0), .ram_wdata(wdat0), .ram_rdata(rrd0)
  );

  data_mem_bridge #(.RAM_AW(10), .RD_LAT(LAT1)) dut1 (
    .clk(clk), .reset(reset), .cpu(bus1),
    .ram_en(en1), .ram_wea(wea1), .ram_addr(ra1), .ram_wdata(wdat1), .ram_rdata(rrd1)
  );

  // Behavioural block RAMs. Read data appears RD_LAT cycles after the enable cycle.
  logic [31:0] ram0[1024];
  logic [31:0] ram1[1024];
  logic [31:0] p0, p1a, p1b, p1c;

  always @(posedge clk) begin
    if (en0) begin
      if (wea0 == 4'b0000) p0 <= ram0[ra0];
      for (int k = 0; k < 4; k++)
        if (wea0[k]) ram0[ra0][8*k +: 8] <= wdat0[8*k +: 8];
    end
  end
  assign rrd0 = p0;

  always @(posedge clk) begin
    if (en1) begin
      if (wea1 == 4'b0000) p1a <= ram1[ra1];
      for (int k = 0; k < 4; k++)
        if (wea1[k]) ram1[ra1][8*k +: 8] <= wdat1[8*k +: 8];
    end
    p1b <= p1a;
    p1c <= p1b;
  end
  assign rrd1 = p1c;

  // Reference model: a flat little-endian byte memory per bridge (4 KiB, so it wraps).
  logic [7:0]  refm[2][4096];
  logic [31:0] last[2];
  exp_t        q0[$];
  exp_t        q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int i, input logic rdy, input logic er, input logic [31:0] rd);
    exp_t e;
    logic empty;
    if (!rdy) begin
      check($sformatf("err_without_ready%0d", i), {31'b0, er}, 32'h0);
    end else begin
      empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready%0d: got cpu_ready=1, required no pending access", i);
      end else begin
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("resp_err%0d", i), {31'b0, er}, {31'b0, e.err});
        check($sformatf("resp_rdata%0d", i), rd, e.rdata);
        check($sformatf("resp_cycle%0d", i), cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ready[0], err[0], rdata[0]);
    mon(1, ready[1], err[1], rdata[1]);
  end

  // Issue one access on bridge i. The bridge must be idle at the next negedge.
  task automatic access(input int i, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] t);
    exp_t        e;
    int          sz;
    int          n;
    logic        bad;
    logic [11:0] ba;
    logic [3:0]  x_wea;
    logic [31:0] x_wd;
    logic [31:0] v;
    sz  = (t == 3'd0) ? 4 : (t <= 3'd2) ? 2 : 1;
    bad = (t > 3'd4) || ((a % sz) != 0);
    ba  = a[11:0];
    x_wea = 4'(((1 << sz) - 1) << a[1:0]);
    x_wd  = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
    if (bad) begin
      e.err = 1'b1; e.rdata = 32'h0; e.lat = 1;
    end else if (w) begin
      for (int k = 0; k < sz; k++) refm[i][ba + k] = d[8*k +: 8];
      e.err = 1'b0; e.rdata = last[i]; e.lat = 2;
    end else begin
      v = 32'h0;
      for (int k = 0; k < sz; k++) v[8*k +: 8] = refm[i][ba + k];
      if (t == 3'd1) v = {{16{v[15]}}, v[15:0]};
      if (t == 3'd3) v = {{24{v[7]}}, v[7:0]};
      e.err = 1'b0; e.rdata = v; e.lat = 2 + ((i == 0) ? LAT0 : LAT1);
    end
    last[i] = e.rdata;

    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wd[i] = d; ty[i] = t;
    e.cyc = cyc + e.lat;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);

    @(negedge clk);
    if (bad) begin
      check("err_ram_en", {31'b0, en_a[i]}, 32'h0);
    end else begin
      check("ram_en", {31'b0, en_a[i]}, 32'h1);
      check("ram_addr", {22'b0, ra_a[i]}, {22'b0, a[11:2]});
      if (w) begin
        check("ram_wea", {28'b0, wea_a[i]}, {28'b0, x_wea});
        check("ram_wdata", wdat_a[i], x_wd);
      end else begin
        check("ram_wea_load", {28'b0, wea_a[i]}, 32'h0);
      end
    end
    n = 0;
    while (!ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready[i]) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout%0d: got no cpu_ready within 20 cycles, required a pulse", i);
    end
    req[i] = 1'b0;
  endtask

  task automatic check_cleared(input int i, input string tag);
    check({tag, "_rdata"}, rdata[i], 32'h0);
    check({tag, "_ready"}, {31'b0, ready[i]}, 32'h0);
    check({tag, "_err"}, {31'b0, err[i]}, 32'h0);
    check({tag, "_en"}, {31'b0, en_a[i]}, 32'h0);
    check({tag, "_wea"}, {28'b0, wea_a[i]}, 32'h0);
    check({tag, "_addr"}, {22'b0, ra_a[i]}, 32'h0);
    check({tag, "_wdata"}, wdat_a[i], 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int unsigned r;
    logic [2:0]  t;
    logic [31:0] a;
    int          sz;
    int          off;

    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; wd[i] = 32'h0; ty[i] = 3'd0;
      last[i] = 32'h0;
      for (int b = 0; b < 4096; b++) refm[i][b] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check_cleared(0, "reset0");
    check_cleared(1, "reset1");
    reset = 1'b1;

    // Zero the region the random phase uses, so the RAMs match the reference.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++) access(i, 1'b1, 32'(w * 4), 32'h0, 3'd0);

    // Bridge 0 (RD_LAT=1): directed cases.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd0);
    access(0, 1'b1, 32'h13, 32'h000000A5, 3'd3);
    access(0, 1'b1, 32'h12, 32'h00001234, 3'd1);
    access(0, 1'b1, 32'h10, 32'h80FF7F01, 3'd0);
    access(0, 1'b0, 32'h12, 32'h0, 3'd3); check("lb_0x12", rdata[0], 32'hFFFFFFFF);
    access(0, 1'b0, 32'h12, 32'h0, 3'd4); check("lbu_0x12", rdata[0], 32'h000000FF);
    access(0, 1'b0, 32'h12, 32'h0, 3'd1); check("lh_0x12", rdata[0], 32'hFFFF80FF);
    access(0, 1'b0, 32'h12, 32'h0, 3'd2); check("lhu_0x12", rdata[0], 32'h000080FF);
    access(0, 1'b0, 32'h10, 32'h0, 3'd0); check("lw_0x10", rdata[0], 32'h80FF7F01);
    access(0, 1'b1, 32'h14, 32'hCAFE0000, 3'd0);
    check("store_holds_rdata", rdata[0], 32'h80FF7F01);
    access(0, 1'b0, 32'h11, 32'h0, 3'd0); check("err_lw_rdata", rdata[0], 32'h0);
    access(0, 1'b1, 32'h13, 32'h5555, 3'd1);
    access(0, 1'b0, 32'h10, 32'h0, 3'd5);
    access(0, 1'b0, 32'h10, 32'h0, 3'd0); check("lw_after_err", rdata[0], 32'h80FF7F01);

    // Bridge 1 (RD_LAT=3).
    access(1, 1'b1, 32'h10, 32'h80FF7F01, 3'd0);
    access(1, 1'b0, 32'h10, 32'h0, 3'd0); check("lw_lat3", rdata[1], 32'h80FF7F01);
    access(1, 1'b0, 32'h12, 32'h0, 3'd3); check("lb_lat3", rdata[1], 32'hFFFFFFFF);
    access(1, 1'b0, 32'h10, 32'h0, 3'd0);

    // Reset during WAIT abandons the load. No ready pulse may follow.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10; ty[1] = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_cleared(1, "midload");
    req[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_ready_in_reset", {31'b0, ready[1]}, 32'h0);
    end
    reset = 1'b1;
    last[0] = 32'h0;
    last[1] = 32'h0;
    repeat (4) @(negedge clk);
    access(1, 1'b0, 32'h10, 32'h0, 3'd0); check("lw_after_reset", rdata[1], 32'h80FF7F01);

    // Random mix on both bridges. The upper address bits are random to exercise wrap.
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) == 0) t = 3'(5 + $urandom_range(0, 2));
      else                           t = 3'($urandom_range(0, 4));
      sz  = (t == 3'd0) ? 4 : (t <= 3'd2) ? 2 : 1;
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 9) != 0) off = off & ~(sz - 1);
      r = $urandom;
      a = (r & 32'hFFFF_F03C) | 32'(off);
      access(n % 2, 1'($urandom_range(0, 1)), a, $urandom, t);
    end

    repeat (3) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
